fractal_sync_pe_ctrl: RTL and testbench
=======================================

FRACTAL_SYNC_PE_CTRL -- requirements
Module: fractal_sync_pe_ctrl

Interface
REQ-001 SHALL have parameter AGGR_WIDTH, default 4: width of aggr_req_o/aggr_rsp_i/req_aggr_i.
REQ-002 SHALL have parameter ID_WIDTH, default 2: width of id fields.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, min 2: watchdog limit (used only with REQ-031).
REQ-004 SHALL have one clock and a synchronous active-low reset, listed first: clk_i  in  1  clock, all state on rising edge; rst_ni  in  1  synchronous active-low reset.
REQ-005 SHALL have PE-side ports: req_valid_i in 1 request valid; req_ready_o out 1 request accepted; req_op_i in 2 00 barrier, 01 lock, 10 free, 11 reserved; req_aggr_i in AGGR_WIDTH aggregation pattern; req_id_i in ID_WIDTH primitive id.
REQ-006 SHALL have PE-side response ports: rsp_valid_o out 1 response valid; rsp_ready_i in 1 response consumed; rsp_error_o out 1 failed request; rsp_timeout_o out 1 failure caused by watchdog.
REQ-007 SHALL have fractal-sync master ports (flattened fractal_sync_if mst_port): sync_o, lock_o, free_o out 1; aggr_req_o out AGGR_WIDTH; id_req_o out ID_WIDTH; wake_i, grant_i, error_i in 1; aggr_rsp_i in AGGR_WIDTH; id_rsp_i in ID_WIDTH.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-009 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i & req_ready_o.
REQ-010 On acceptance, op/aggr/id SHALL be registered; valid op -> ISSUE; reserved op -> RESP with rsp_error_o=1, nothing issued.
REQ-011 In ISSUE, exactly one of sync_o (barrier), lock_o (lock), free_o (free) SHALL be 1 for exactly one cycle, with aggr_req_o/id_req_o = registered values.
REQ-012 aggr_req_o/id_req_o SHALL be 0 in every state other than ISSUE; sync_o/lock_o/free_o SHALL be 0 outside ISSUE.
REQ-013 Free SHALL go ISSUE -> RESP with rsp_error_o=0 (no tree response expected).
REQ-014 Barrier/lock SHALL go ISSUE -> WAIT unless a matching response occurs in the ISSUE cycle, in which case ISSUE -> RESP directly.
REQ-015 Barrier match: wake_i=1 and id_rsp_i == registered id (aggr_rsp_i ignored).
REQ-016 Lock match: grant_i=1, id_rsp_i == registered id, aggr_rsp_i == registered aggr.
REQ-017 Error match: error_i=1 and id_rsp_i == registered id, for either op; error match SHALL take priority over wake/grant in the same cycle and set rsp_error_o=1.
REQ-018 Non-matching responses, grant during barrier, wake during lock, and any response in IDLE/RESP SHALL be ignored with no state change.
REQ-019 On match in ISSUE/WAIT, next state SHALL be RESP with rsp_error_o per REQ-017, rsp_timeout_o=0.
REQ-020 In RESP, rsp_valid_o=1 and rsp_error_o/rsp_timeout_o stable until rsp_ready_i=1; then -> IDLE.
REQ-021 Minimum latency: accept at cycle N, pulse at N+1, rsp_valid_o at N+2 if matched at N+1.
REQ-022 At most one outstanding request; no new request accepted in same cycle as response handshake (IDLE entered next cycle).

Reset
REQ-023 While rst_ni=0 at a rising edge, state SHALL become IDLE and registered op/aggr/id/error/timeout flags and watchdog counter SHALL clear to 0.
REQ-024 Reset values: req_ready_o=1, rsp_valid_o=0, rsp_error_o=0, rsp_timeout_o=0, sync_o=lock_o=free_o=0, aggr_req_o=0, id_req_o=0.
REQ-025 Reset in ISSUE/WAIT/RESP SHALL abandon the operation; no response is produced for it.

Configuration
REQ-030 Macro FRACTAL_SYNC_PE_TIMEOUT_EN SHALL control the watchdog; port list identical either way.
REQ-031 With it defined: counter clears on entry to WAIT, increments each WAIT cycle; when it reaches TIMEOUT_CYCLES-1 without match -> RESP with rsp_error_o=1, rsp_timeout_o=1; a match in that same cycle wins.
REQ-032 Without it: WAIT persists indefinitely; rsp_timeout_o tied 0; no counter logic.

Verification
REQ-040 Barrier op=00 id=1 aggr=0b0011; wake_i with id_rsp_i=1 three cycles after pulse -> single sync_o pulse with aggr_req_o=0b0011, id_req_o=1; rsp_valid_o, rsp_error_o=0.
REQ-041 Lock id=2 aggr=0b0101; grant_i with id=2 aggr=0b0100 (ignored), then id=2 aggr=0b0101 -> stays WAIT on first, RESP on second.
REQ-042 Free id=3 -> one free_o pulse, rsp_valid_o two cycles after acceptance, error=0; rsp_ready_i held 0 for 5 cycles -> response held stable.
REQ-043 Op=11 -> no sync/lock/free pulse, rsp_error_o=1; barrier with simultaneous error_i and wake_i same id -> rsp_error_o=1.
REQ-044 With FRACTAL_SYNC_PE_TIMEOUT_EN, TIMEOUT_CYCLES=8, barrier never woken -> rsp_error_o=1, rsp_timeout_o=1 after 8 WAIT cycles; without macro, still in WAIT after 100 cycles.
REQ-045 rst_ni=0 during WAIT -> next cycle all outputs at reset values; later matching wake_i produces no response.

Source files
------------

// File: rtl/fractal_sync_pe_ctrl.sv
// fractal_sync_pe_ctrl: bridges one processing element's synchronisation
// requests (barrier / lock / free) onto a fractal-sync tree master port and
// returns a single response per request.
//
// Optional feature macro: FRACTAL_SYNC_PE_TIMEOUT_EN enables a watchdog on the
// WAIT state. When the watchdog fires, the request fails with rsp_timeout_o set.
// The port list is the same whether or not the macro is defined.
//
// Handshake: a request transfers on a cycle where req_valid_i && req_ready_o.
// A response transfers on a cycle where rsp_valid_o && rsp_ready_i. While
// rsp_valid_o is high, rsp_error_o and rsp_timeout_o do not change.
module fractal_sync_pe_ctrl #(
  parameter int AGGR_WIDTH     = 4,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // PE request side
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [AGGR_WIDTH-1:0] req_aggr_i,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  // PE response side
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_error_o,
  output logic                  rsp_timeout_o,
  // fractal-sync master port
  output logic                  sync_o,
  output logic                  lock_o,
  output logic                  free_o,
  output logic [AGGR_WIDTH-1:0] aggr_req_o,
  output logic [ID_WIDTH-1:0]   id_req_o,
  input  logic                  wake_i,
  input  logic                  grant_i,
  input  logic                  error_i,
  input  logic [AGGR_WIDTH-1:0] aggr_rsp_i,
  input  logic [ID_WIDTH-1:0]   id_rsp_i,
  // FSM state, for observation only
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_BARRIER = 2'b00;
  localparam logic [1:0] OP_LOCK    = 2'b01;
  localparam logic [1:0] OP_FREE    = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  // The watchdog cannot express a limit below two cycles.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [AGGR_WIDTH-1:0] aggr_q, aggr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  err_q, err_d;

  logic id_hit, err_match, ok_match;

`ifdef FRACTAL_SYNC_PE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q, tmo_d;
`endif

  // Tree response matching against the request currently held. Errors win
  // over wake/grant, so they are resolved separately in the FSM.
  always_comb begin
    id_hit    = (id_rsp_i == id_q);
    err_match = error_i && id_hit;
    ok_match  = ((op_q == OP_BARRIER) && wake_i && id_hit) ||
                ((op_q == OP_LOCK) && grant_i && id_hit && (aggr_rsp_i == aggr_q));
  end

  // Next-state and request/flag capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    aggr_d  = aggr_q;
    id_d    = id_q;
    err_d   = err_q;
`ifdef FRACTAL_SYNC_PE_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d   = req_op_i;
          aggr_d = req_aggr_i;
          id_d   = req_id_i;
          err_d  = 1'b0;
`ifdef FRACTAL_SYNC_PE_TIMEOUT_EN
          tmo_d  = 1'b0;
`endif
          // A reserved op is refused without touching the tree.
          if (req_op_i == OP_RSVD) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_q == OP_FREE) begin
          state_d = RESP;
        end else if (err_match) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (ok_match) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (err_match) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (ok_match) begin
          state_d = RESP;
`ifdef FRACTAL_SYNC_PE_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      aggr_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      aggr_q  <= aggr_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

`ifdef FRACTAL_SYNC_PE_TIMEOUT_EN
  // Watchdog: restarts on entry to WAIT, counts every WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if ((state_q != WAIT) && (state_d == WAIT)) cnt_q <= '0;
      else if (state_q == WAIT)                   cnt_q <= cnt_q + 1'b1;
    end
  end
  assign rsp_timeout_o = (state_q == RESP) && tmo_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // Outputs decoded from the current state only.
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_error_o = (state_q == RESP) && err_q;
  assign sync_o      = (state_q == ISSUE) && (op_q == OP_BARRIER);
  assign lock_o      = (state_q == ISSUE) && (op_q == OP_LOCK);
  assign free_o      = (state_q == ISSUE) && (op_q == OP_FREE);
  assign aggr_req_o  = (state_q == ISSUE) ? aggr_q : '0;
  assign id_req_o    = (state_q == ISSUE) ? id_q : '0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fractal_sync_pe_ctrl.sv
// Testbench for fractal_sync_pe_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level response model.
module tb_fractal_sync_pe_ctrl;

  localparam int TO = 8;   // watchdog limit used for the DUT instance
  localparam int L  = 16;  // response-event window per random transaction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       req_valid, rsp_ready, wake, grant, error;
  logic [1:0] req_op, req_id, id_rsp;
  logic [3:0] req_aggr, aggr_rsp;
  logic       req_ready, rsp_valid, rsp_error, rsp_timeout;
  logic       sync_p, lock_p, free_p;
  logic [3:0] aggr_req;
  logic [1:0] id_req, dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard of expected responses {error, timeout}
  logic [1:0] exp_q[$];

  // response events for one random transaction, indexed by cycle after accept
  bit         ev_wake[L];
  bit         ev_grant[L];
  bit         ev_err[L];
  logic [1:0] ev_id[L];
  logic [3:0] ev_aggr[L];

  fractal_sync_pe_ctrl #(.AGGR_WIDTH(4), .ID_WIDTH(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_aggr_i(req_aggr), .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_error_o(rsp_error),
    .rsp_timeout_o(rsp_timeout),
    .sync_o(sync_p), .lock_o(lock_p), .free_o(free_p),
    .aggr_req_o(aggr_req), .id_req_o(id_req),
    .wake_i(wake), .grant_i(grant), .error_i(error),
    .aggr_rsp_i(aggr_rsp), .id_rsp_i(id_rsp),
    .dbg_state_o(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_tree();
    wake = 0; grant = 0; error = 0; id_rsp = 0; aggr_rsp = 0;
  endtask

  task automatic drive_tree(input bit w, input bit g, input bit e,
                            input logic [1:0] id, input logic [3:0] ag);
    wake = w; grant = g; error = e; id_rsp = id; aggr_rsp = ag;
  endtask

  // present a request in IDLE; returns #1 after the accepting edge
  task automatic accept(input logic [1:0] op, input logic [3:0] ag, input logic [1:0] id);
    req_valid = 1; req_op = op; req_aggr = ag; req_id = id;
    step();
    req_valid = 0;
  endtask

  task automatic respond_ready();
    rsp_ready = 1;
    step();
    rsp_ready = 0;
  endtask

  // ---------------- reference model ----------------
  // Given the op and the tree events of each cycle after acceptance (cycle 0
  // is the issue pulse), return the cycle on which the request resolves
  // (-1 = resolved at acceptance) and its error/timeout result.
  function automatic void model(input logic [1:0] op, input logic [3:0] ag,
                                input logic [1:0] id, output int hit,
                                output bit err, output bit tmo);
    hit = L - 1; err = 0; tmo = 0;
    if (op == 2'b11) begin hit = -1; err = 1; return; end
    if (op == 2'b10) begin hit = 0; return; end
    for (int k = 0; k < L; k++) begin
      if (ev_err[k] && ev_id[k] == id) begin hit = k; err = 1; return; end
      if (op == 2'b00 && ev_wake[k] && ev_id[k] == id) begin hit = k; return; end
      if (op == 2'b01 && ev_grant[k] && ev_id[k] == id && ev_aggr[k] == ag) begin
        hit = k; return;
      end
`ifdef FRACTAL_SYNC_PE_TIMEOUT_EN
      // WAIT occupies cycles 1..; the watchdog gives up after TO of them
      if (k == TO) begin hit = k; err = 1; tmo = 1; return; end
`endif
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; req_valid = 1; req_op = 2'b01; req_aggr = 4'hf; req_id = 2'd3;
    rsp_ready = 0; drive_tree(1, 1, 1, 2'd3, 4'hf);
    step(); step();
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_vec++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b000) begin n_err++; $display("FAIL reset_rsp: got %b want 000", {rsp_valid, rsp_error, rsp_timeout}); end
    n_vec++; if ({sync_p, lock_p, free_p, aggr_req, id_req} !== 9'd0) begin n_err++; $display("FAIL reset_tree: got %h want 0", {sync_p, lock_p, free_p, aggr_req, id_req}); end
    req_valid = 0; clear_tree();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_barrier();
    accept(2'b00, 4'b0011, 2'd1);
    @(negedge clk);
    n_vec++; if ({sync_p, lock_p, free_p} !== 3'b100 || aggr_req !== 4'b0011 || id_req !== 2'd1) begin n_err++; $display("FAIL barrier_pulse: got %b/%h/%h want 100/3/1", {sync_p, lock_p, free_p}, aggr_req, id_req); end
    for (int c = 1; c <= 2; c++) begin
      step(); @(negedge clk);
      n_vec++; if ({sync_p, lock_p, free_p, aggr_req, id_req, rsp_valid} !== 10'd0) begin n_err++; $display("FAIL barrier_wait%0d: got %h want 0", c, {sync_p, lock_p, free_p, aggr_req, id_req, rsp_valid}); end
    end
    step(); drive_tree(1, 0, 0, 2'd1, 4'($urandom_range(0, 15)));
    step(); clear_tree();
    @(negedge clk);
    n_vec++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b100) begin n_err++; $display("FAIL barrier_rsp: got %b want 100", {rsp_valid, rsp_error, rsp_timeout}); end
    respond_ready(); @(negedge clk);
    n_vec++; if ({req_ready, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL barrier_idle: got %b want 10", {req_ready, rsp_valid}); end
    step();
  endtask

  task automatic test_lock();
    accept(2'b01, 4'b0101, 2'd2);
    @(negedge clk);
    n_vec++; if ({sync_p, lock_p, free_p} !== 3'b010 || aggr_req !== 4'b0101 || id_req !== 2'd2) begin n_err++; $display("FAIL lock_pulse: got %b/%h/%h want 010/5/2", {sync_p, lock_p, free_p}, aggr_req, id_req); end
    step(); drive_tree(0, 1, 0, 2'd2, 4'b0100);   // wrong aggr
    step(); drive_tree(1, 0, 0, 2'd2, 4'b0101);   // wake during lock
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lock_bad_aggr: got %b want 0", rsp_valid); end
    step(); drive_tree(0, 1, 0, 2'd2, 4'b0101);
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lock_wake_ignored: got %b want 0", rsp_valid); end
    step(); clear_tree(); @(negedge clk);
    n_vec++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b100) begin n_err++; $display("FAIL lock_rsp: got %b want 100", {rsp_valid, rsp_error, rsp_timeout}); end
    respond_ready(); step();
  endtask

  task automatic test_free_hold();
    accept(2'b10, 4'($urandom_range(0, 15)), 2'd3);
    @(negedge clk);
    n_vec++; if ({sync_p, lock_p, free_p} !== 3'b001 || id_req !== 2'd3 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL free_pulse: got %b/%h/%b want 001/3/0", {sync_p, lock_p, free_p}, id_req, rsp_valid); end
    step();
    for (int c = 0; c < 5; c++) begin
      drive_tree(1'($urandom), 1'($urandom), 1'($urandom), 2'd3, 4'($urandom));
      @(negedge clk);
      n_vec++; if ({rsp_valid, rsp_error, rsp_timeout, free_p} !== 4'b1000) begin n_err++; $display("FAIL free_hold%0d: got %b want 1000", c, {rsp_valid, rsp_error, rsp_timeout, free_p}); end
      step();
    end
    clear_tree(); respond_ready(); step();
  endtask

  task automatic test_reserved_and_error();
    accept(2'b11, 4'hf, 2'd1);
    @(negedge clk);
    n_vec++; if ({sync_p, lock_p, free_p, aggr_req, id_req} !== 9'd0) begin n_err++; $display("FAIL rsvd_no_issue: got %h want 0", {sync_p, lock_p, free_p, aggr_req, id_req}); end
    n_vec++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b110) begin n_err++; $display("FAIL rsvd_rsp: got %b want 110", {rsp_valid, rsp_error, rsp_timeout}); end
    respond_ready(); step();
    accept(2'b00, 4'h6, 2'd1);
    drive_tree(1, 0, 1, 2'd1, 4'h6);
    step(); clear_tree(); @(negedge clk);
    n_vec++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b110) begin n_err++; $display("FAIL err_priority: got %b want 110", {rsp_valid, rsp_error, rsp_timeout}); end
    respond_ready(); step();
  endtask

  task automatic test_timeout();
    accept(2'b00, 4'h9, 2'd0);
`ifdef FRACTAL_SYNC_PE_TIMEOUT_EN
    for (int w = 0; w < TO; w++) begin
      step(); @(negedge clk);
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL tmo_wait%0d: got %b want 0", w, rsp_valid); end
    end
    step(); @(negedge clk);
    n_vec++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b111) begin n_err++; $display("FAIL tmo_rsp: got %b want 111", {rsp_valid, rsp_error, rsp_timeout}); end
`else
    for (int w = 0; w < 100; w++) begin
      step(); @(negedge clk);
      if (w % 25 == 24) begin
        n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL wait_forever%0d: got %b want 00", w, {rsp_valid, req_ready}); end
      end
    end
    step(); drive_tree(0, 0, 1, 2'd0, 4'h0);
    step(); clear_tree(); @(negedge clk);
    n_vec++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b110) begin n_err++; $display("FAIL wait_err_exit: got %b want 110", {rsp_valid, rsp_error, rsp_timeout}); end
`endif
    respond_ready(); step();
  endtask

  task automatic test_reset_in_wait();
    accept(2'b01, 4'h3, 2'd1);
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    @(negedge clk);
    n_vec++; if ({req_ready, rsp_valid, rsp_error, rsp_timeout, sync_p, lock_p, free_p, aggr_req, id_req} !== 13'h1000) begin n_err++; $display("FAIL rst_wait_outputs: got %h want 1000", {req_ready, rsp_valid, rsp_error, rsp_timeout, sync_p, lock_p, free_p, aggr_req, id_req}); end
    step(); drive_tree(1, 1, 0, 2'd1, 4'h3);
    step(); clear_tree();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if ({req_ready, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL rst_wait_no_rsp%0d: got %b want 10", c, {req_ready, rsp_valid}); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    accept(2'b10, 4'h1, 2'd2);
    step();   // now in response phase
    rsp_ready = 1; req_valid = 1; req_op = 2'b10; req_aggr = 4'h2; req_id = 2'd1;
    @(negedge clk);
    n_vec++; if ({req_ready, rsp_valid} !== 2'b01) begin n_err++; $display("FAIL b2b_handshake: got %b want 01", {req_ready, rsp_valid}); end
    step(); rsp_ready = 0; @(negedge clk);
    n_vec++; if ({req_ready, free_p} !== 2'b10) begin n_err++; $display("FAIL b2b_idle: got %b want 10", {req_ready, free_p}); end
    step(); req_valid = 0; @(negedge clk);
    n_vec++; if (free_p !== 1'b1 || id_req !== 2'd1) begin n_err++; $display("FAIL b2b_second: got %b/%h want 1/1", free_p, id_req); end
    step(); respond_ready(); step();
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [1:0] op, id;
      logic [3:0] ag;
      logic [1:0] got;
      int hit;
      bit e, tm;
      op = 2'($urandom_range(0, 3));
      id = 2'($urandom_range(0, 3));
      ag = 4'($urandom_range(0, 15));
      for (int k = 0; k < L; k++) begin
        ev_wake[k]  = ($urandom_range(0, 5) == 0);
        ev_grant[k] = ($urandom_range(0, 5) == 0);
        ev_err[k]   = ($urandom_range(0, 11) == 0);
        ev_id[k]    = 2'($urandom_range(0, 3));
        ev_aggr[k]  = $urandom_range(0, 1) ? ag : 4'($urandom_range(0, 15));
      end
      ev_err[L-1] = 1; ev_id[L-1] = id;
      model(op, ag, id, hit, e, tm);
      exp_q.push_back({e, tm});
      accept(op, ag, id);
      for (int k = 0; k <= hit; k++) begin
        logic [2:0] exp_p;
        exp_p = (k != 0) ? 3'b000 : (op == 2'b00) ? 3'b100 : (op == 2'b01) ? 3'b010 : 3'b001;
        drive_tree(ev_wake[k], ev_grant[k], ev_err[k], ev_id[k], ev_aggr[k]);
        @(negedge clk);
        n_vec++; if ({sync_p, lock_p, free_p} !== exp_p || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rnd%0d_cycle%0d: got %b/%b want %b/0", t, k, {sync_p, lock_p, free_p}, rsp_valid, exp_p); end
        n_vec++; if (aggr_req !== ((k == 0) ? ag : 4'h0) || id_req !== ((k == 0) ? id : 2'd0)) begin n_err++; $display("FAIL rnd%0d_fields%0d: got %h/%h want %h/%h", t, k, aggr_req, id_req, (k == 0) ? ag : 4'h0, (k == 0) ? id : 2'd0); end
        step();
      end
      clear_tree();
      got = exp_q.pop_front();
      for (int h = $urandom_range(0, 3); h >= 0; h--) begin
        @(negedge clk);
        n_vec++; if ({rsp_valid, rsp_error, rsp_timeout} !== {1'b1, got}) begin n_err++; $display("FAIL rnd%0d_rsp: got %b want %b op=%0d", t, {rsp_valid, rsp_error, rsp_timeout}, {1'b1, got}, op); end
        if (h != 0) begin
          step();
          drive_tree(1'($urandom), 1'($urandom), 1'($urandom), id, ag);
        end
      end
      clear_tree();
      respond_ready();
      @(negedge clk);
      n_vec++; if ({req_ready, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL rnd%0d_idle: got %b want 10", t, {req_ready, rsp_valid}); end
      step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    req_valid = 0; req_op = 0; req_aggr = 0; req_id = 0; rsp_ready = 0;
    clear_tree();
    test_reset();
    test_barrier();
    test_lock();
    test_free_hold();
    test_reserved_and_error();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
